// File: rtl/mc16_pkg.sv
// Shared definitions for the 16-bit multi-cycle control unit: opcodes,
// ALU operation codes (also used by the ALU) and controller state encodings.
package mc16_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } ctrl_state_e;

endpackage

// File: rtl/mc16_alu_dec.sv
// Combinational instruction decode: opcode/funct3 to ALU operation,
// B-operand select and legality.
module mc16_alu_dec
  import mc16_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [2:0] i_funct3,
  output alu_op_e    o_alu_ctrl,
  output logic       o_alu_src_imm,
  output logic       o_legal
);

  always_comb begin
    o_alu_ctrl    = ALU_ADD;
    o_alu_src_imm = 1'b0;
    o_legal       = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        // funct3 maps straight onto the ALU op; 110/111 have no ALU meaning
        o_alu_ctrl = alu_op_e'(i_funct3);
        o_legal    = (i_funct3 <= 3'd5);
      end
      OP_ADDI, OP_LW, OP_SW: begin
        o_alu_ctrl    = ALU_ADD;
        o_alu_src_imm = 1'b1;
        o_legal       = 1'b1;
      end
      OP_BEQ: begin
        o_alu_ctrl = ALU_SUB;
        o_legal    = 1'b1;
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl16.sv
// Multi-cycle control unit: fetches into IR, decodes, and sequences ALU,
// register-file, data-memory and PC strobes through FETCH/DECODE/EXEC/MEM/WB.
module mc_ctrl16
  import mc16_pkg::*;
#(
  parameter int IMM_W            = 6,
  parameter int RESET_TRAP_CLEAR = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic [2:0]  alu_ctrl,
  output logic        alu_src_imm,
  input  logic        alu_zero,
  output logic [2:0]  rs1_addr,
  output logic [2:0]  rs2_addr,
  output logic [2:0]  rd_addr,
  output logic [15:0] imm,
  output logic        reg_we,
  output logic        wb_from_mem,
  output logic        pc_we,
  output logic        pc_branch,
  output logic        retire,
  output logic        illegal,
  output logic [2:0]  state_dbg
);

  ctrl_state_e r_state;
  logic [15:0] r_ir;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  alu_op_e     r_alu_ctrl;
  logic        r_alu_src_imm;
  logic        r_reg_we;
  logic        r_wb_from_mem;
  logic        r_pc_we;
  logic        r_retire;
  logic        r_beq_exec;
  logic        r_illegal;

  logic [3:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic [2:0]  w_funct3;
  alu_op_e     w_dec_ctrl;
  logic        w_dec_src_imm;
  logic        w_dec_legal;
  logic        w_sw_done;

  assign w_op     = r_ir[15:12];
  assign w_rd     = r_ir[11:9];
  assign w_rs1    = r_ir[8:6];
  assign w_rs2    = r_ir[5:3];
  assign w_funct3 = r_ir[2:0];

  mc16_alu_dec u_alu_dec (
    .i_op          (w_op),
    .i_funct3      (w_funct3),
    .o_alu_ctrl    (w_dec_ctrl),
    .o_alu_src_imm (w_dec_src_imm),
    .o_legal       (w_dec_legal)
  );

  // A store retires in the very cycle memory accepts it, so its strobes
  // cannot wait for a register stage.
  assign w_sw_done = r_dmem_req && r_dmem_we && dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_ir          <= 16'h0;
      r_imem_req    <= 1'b0;
      r_dmem_req    <= 1'b0;
      r_dmem_we     <= 1'b0;
      r_alu_ctrl    <= ALU_ADD;
      r_alu_src_imm <= 1'b0;
      r_reg_we      <= 1'b0;
      r_wb_from_mem <= 1'b0;
      r_pc_we       <= 1'b0;
      r_retire      <= 1'b0;
      r_beq_exec    <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_reg_we   <= 1'b0;
      r_pc_we    <= 1'b0;
      r_retire   <= 1'b0;
      r_beq_exec <= 1'b0;
      unique case (r_state)
        ST_FETCH: begin
          if (r_imem_req && imem_valid) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (!w_dec_legal) begin
            r_state   <= ST_TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state       <= ST_EXEC;
            r_alu_ctrl    <= w_dec_ctrl;
            r_alu_src_imm <= w_dec_src_imm;
            // A branch resolves in EXEC, so its PC/retire strobes arm now
            if (w_op == OP_BEQ) begin
              r_pc_we    <= 1'b1;
              r_retire   <= 1'b1;
              r_beq_exec <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (w_op == OP_BEQ) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b1;
          end else if (w_op == OP_LW || w_op == OP_SW) begin
            r_state    <= ST_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= (w_op == OP_SW);
          end else begin
            r_state       <= ST_WB;
            r_reg_we      <= (w_rd != 3'd0);
            r_wb_from_mem <= 1'b0;
            r_pc_we       <= 1'b1;
            r_retire      <= 1'b1;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (w_op == OP_SW) begin
              r_state    <= ST_FETCH;
              r_imem_req <= 1'b1;
            end else begin
              r_state       <= ST_WB;
              r_reg_we      <= (w_rd != 3'd0);
              r_wb_from_mem <= 1'b1;
              r_pc_we       <= 1'b1;
              r_retire      <= 1'b1;
            end
          end
        end
        ST_WB: begin
          r_state       <= ST_FETCH;
          r_imem_req    <= 1'b1;
          r_wb_from_mem <= 1'b0;
        end
        ST_TRAP: begin
          r_illegal <= 1'b1;
          if (RESET_TRAP_CLEAR == 0) begin
            r_state    <= ST_FETCH;
            r_illegal  <= 1'b0;
            r_imem_req <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_TRAP;
          r_illegal <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign dmem_req    = r_dmem_req;
  assign dmem_we     = r_dmem_we;
  assign alu_ctrl    = r_alu_ctrl;
  assign alu_src_imm = r_alu_src_imm;
  assign rs1_addr    = w_rs1;
  // Stores and branches read their second register from the rd field
  assign rs2_addr    = (w_op == OP_SW || w_op == OP_BEQ) ? w_rd : w_rs2;
  assign rd_addr     = w_rd;
  assign imm         = {{(16 - IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
  assign reg_we      = r_reg_we;
  assign wb_from_mem = r_wb_from_mem;
  assign pc_we       = r_pc_we | w_sw_done;
  assign pc_branch   = r_beq_exec & alu_zero;
  assign retire      = r_retire | w_sw_done;
  assign illegal     = r_illegal;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_mc_ctrl16.sv
// Directed bench for mc_ctrl16: walks each instruction class cycle by cycle
// against hand-computed control values.
module tb_mc_ctrl16;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic [2:0]  alu_ctrl;
  logic        alu_src_imm;
  logic        alu_zero;
  logic [2:0]  rs1_addr;
  logic [2:0]  rs2_addr;
  logic [2:0]  rd_addr;
  logic [15:0] imm;
  logic        reg_we;
  logic        wb_from_mem;
  logic        pc_we;
  logic        pc_branch;
  logic        retire;
  logic        illegal;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int t_start  = 0;
  int n_req    = 0;

  mc_ctrl16 #(.IMM_W(6), .RESET_TRAP_CLEAR(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .alu_ctrl    (alu_ctrl),
    .alu_src_imm (alu_src_imm),
    .alu_zero    (alu_zero),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .imm         (imm),
    .reg_we      (reg_we),
    .wb_from_mem (wb_from_mem),
    .pc_we       (pc_we),
    .pc_branch   (pc_branch),
    .retire      (retire),
    .illegal     (illegal),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  // Present an instruction in a FETCH cycle with imem_req already high.
  task automatic fetch(input logic [15:0] instr);
    check("fetch_req", {15'h0, imem_req}, 16'h1);
    t_start    = cycle;
    imem_rdata = instr;
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    check("decode_state", {13'h0, state_dbg}, 16'h1);
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 16'h0;
    dmem_ready = 1'b0;
    alu_zero   = 1'b0;
    tick();
    tick();
    check("rst_state", {13'h0, state_dbg}, 16'h0);
    check("rst_strobes", {11'h0, imem_req, dmem_req, reg_we, pc_we, retire}, 16'h0);
    check("rst_illegal", {15'h0, illegal}, 16'h0);
    check("rst_alu_ctrl", {13'h0, alu_ctrl}, 16'h0);
    rst = 1'b0;
    tick();
    check("post_rst_req", {15'h0, imem_req}, 16'h1);
    check("post_rst_state", {13'h0, state_dbg}, 16'h0);
    check("post_rst_strobes", {12'h0, dmem_req, reg_we, pc_we, retire}, 16'h0);

    // R-type SUB rd=1 rs1=2 rs2=0, one wait cycle on imem first
    tick();
    check("imem_wait_state", {13'h0, state_dbg}, 16'h0);
    fetch(16'h0281);
    check("r_rd", {13'h0, rd_addr}, 16'h1);
    check("r_rs1", {13'h0, rs1_addr}, 16'h2);
    check("r_rs2", {13'h0, rs2_addr}, 16'h0);
    check("r_decode_req", {15'h0, imem_req}, 16'h0);
    imem_valid = 1'b1;            // must be ignored while imem_req is low
    imem_rdata = 16'hFFFF;
    tick();
    check("r_exec_state", {13'h0, state_dbg}, 16'h2);
    check("r_alu_ctrl", {13'h0, alu_ctrl}, 16'h1);
    check("r_src_imm", {15'h0, alu_src_imm}, 16'h0);
    check("r_ir_held", {13'h0, rd_addr}, 16'h1);
    check("r_exec_strobes", {13'h0, reg_we, pc_we, retire}, 16'h0);
    imem_valid = 1'b0;
    tick();
    check("r_wb_state", {13'h0, state_dbg}, 16'h4);
    check("r_wb_strobes", {12'h0, reg_we, pc_we, retire, pc_branch}, 16'hE);
    check("r_wb_src", {15'h0, wb_from_mem}, 16'h0);
    check("r_latency", 16'(cycle - t_start + 1), 16'd4);
    $display("instr 0281 R-type SUB retired at cycle %0d", cycle);
    tick();
    check("r_back_fetch", {12'h0, imem_req, reg_we, pc_we, retire}, 16'h8);

    // ADDI rd=3 rs1=1 imm=-2
    fetch(16'h167E);
    check("addi_imm", imm, 16'hFFFE);
    check("addi_rd", {13'h0, rd_addr}, 16'h3);
    tick();
    check("addi_src_imm", {15'h0, alu_src_imm}, 16'h1);
    check("addi_alu_ctrl", {13'h0, alu_ctrl}, 16'h0);
    tick();
    check("addi_wb_strobes", {13'h0, reg_we, pc_we, retire}, 16'h7);
    $display("instr 167E ADDI retired at cycle %0d", cycle);
    tick();

    // R-type ADD with rd=0: no register write, still retires
    fetch(16'h0008);
    tick();
    tick();
    check("rd0_wb_strobes", {13'h0, reg_we, pc_we, retire}, 16'h3);
    $display("instr 0008 R-type rd=0 retired at cycle %0d", cycle);
    tick();

    // LW rd=2 rs1=1 imm=4, dmem_ready after 3 wait cycles
    fetch(16'h2444);
    tick();
    check("lw_exec_state", {13'h0, state_dbg}, 16'h2);
    tick();
    n_req = 0;
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_wait", {13'h0, state_dbg}, 16'h3);
      check("lw_dmem_wait_req", {14'h0, dmem_req, dmem_we}, 16'h2);
      check("lw_mem_no_retire", {14'h0, pc_we, retire}, 16'h0);
      if (dmem_req) n_req++;
      tick();
    end
    dmem_ready = 1'b1;
    check("lw_dmem_ready_req", {14'h0, dmem_req, dmem_we}, 16'h2);
    if (dmem_req) n_req++;
    tick();
    dmem_ready = 1'b0;
    check("lw_req_cycles", 16'(n_req), 16'd4);
    check("lw_wb_state", {13'h0, state_dbg}, 16'h4);
    check("lw_wb_src", {15'h0, wb_from_mem}, 16'h1);
    check("lw_wb_strobes", {12'h0, dmem_req, reg_we, pc_we, retire}, 16'h7);
    check("lw_latency", 16'(cycle - t_start + 1), 16'd8);
    $display("instr 2444 LW retired at cycle %0d", cycle);
    tick();

    // SW data=r5 base=r1 imm=2, zero-wait memory
    fetch(16'h3A42);
    check("sw_rs2_from_rd", {13'h0, rs2_addr}, 16'h5);
    tick();
    dmem_ready = 1'b1;
    tick();
    check("sw_mem_state", {13'h0, state_dbg}, 16'h3);
    check("sw_mem_strobes", {12'h0, dmem_req, dmem_we, pc_we, retire}, 16'hF);
    check("sw_no_reg_we", {15'h0, reg_we}, 16'h0);
    check("sw_latency", 16'(cycle - t_start + 1), 16'd4);
    $display("instr 3A42 SW retired at cycle %0d", cycle);
    tick();
    dmem_ready = 1'b0;
    check("sw_back_fetch", {12'h0, state_dbg == 3'd0, dmem_req, pc_we, retire}, 16'h8);

    // BEQ rd=1 rs1=2, taken then not taken
    for (int k = 0; k < 2; k++) begin
      fetch(16'h4283);
      check("beq_rs2_from_rd", {13'h0, rs2_addr}, 16'h1);
      check("beq_rs1", {13'h0, rs1_addr}, 16'h2);
      alu_zero = (k == 0);
      tick();
      check("beq_exec_state", {13'h0, state_dbg}, 16'h2);
      check("beq_alu_ctrl", {13'h0, alu_ctrl}, 16'h1);
      check("beq_strobes", {12'h0, reg_we, pc_we, retire, pc_branch}, (k == 0) ? 16'h7 : 16'h6);
      check("beq_latency", 16'(cycle - t_start + 1), 16'd3);
      $display("instr 4283 BEQ zero=%0d retired at cycle %0d", alu_zero, cycle);
      tick();
      alu_zero = 1'b0;
      check("beq_back_fetch", {13'h0, state_dbg}, 16'h0);
      check("beq_after_pc_we", {15'h0, pc_we}, 16'h0);
    end

    // Reset while a load waits in MEM aborts it at once
    fetch(16'h2444);
    tick();
    tick();
    check("abort_pre_req", {15'h0, dmem_req}, 16'h1);
    rst = 1'b1;
    tick();
    check("abort_strobes", {12'h0, dmem_req, reg_we, pc_we, retire}, 16'h0);
    check("abort_state", {13'h0, state_dbg}, 16'h0);
    $display("instr 2444 LW aborted by reset at cycle %0d", cycle);
    rst = 1'b0;
    tick();

    // R-type funct3=111 is illegal and locks up until reset
    fetch(16'h0007);
    tick();
    check("trap_state", {13'h0, state_dbg}, 16'h7);
    check("trap_illegal", {15'h0, illegal}, 16'h1);
    imem_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("trap_hold", {10'h0, illegal, imem_req, dmem_req, reg_we, pc_we, retire}, 16'h20);
      tick();
    end
    imem_valid = 1'b0;
    check("trap_still", {13'h0, state_dbg}, 16'h7);
    $display("instr 0007 illegal, trapped at cycle %0d", cycle);
    rst = 1'b1;
    tick();
    check("trap_rst_state", {13'h0, state_dbg}, 16'h0);
    check("trap_rst_illegal", {15'h0, illegal}, 16'h0);
    rst = 1'b0;
    tick();
    check("trap_rst_req", {15'h0, imem_req}, 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl16.md
Name: mc_ctrl16

Overview:
- Multi-cycle control unit for the 16-bit RISC-V-style core; the producer side of the ALU's `alu_ctrl`/`zero` interface.
- Fetches a 16-bit instruction over an imem handshake and latches it into an internal IR.
- Decodes it and sequences ALU, register-file, data-memory and PC enables across FETCH/DECODE/EXEC/MEM/WB states.
- Sits between instruction/data memory ports and the datapath (regfile, ALU, PC register).

Parameters:
- IMM_W, 6, width of the immediate field; sign-extended to 16 bits.
- RESET_TRAP_CLEAR, 1, when 1 a synchronous reset is the only exit from TRAP (fixed behaviour; kept for lint visibility).

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, held until imem_valid
- imem_valid  in  1  instruction data valid this cycle
- imem_rdata  in  16  instruction word, sampled when imem_req&&imem_valid
- dmem_req  out  1  data access request, held until dmem_ready
- dmem_we  out  1  1=store, 0=load; valid while dmem_req
- dmem_ready  in  1  data access completes this cycle
- alu_ctrl  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT
- alu_src_imm  out  1  ALU b operand: 1=imm, 0=rs2 data
- alu_zero  in  1  ALU zero flag
- rs1_addr, rs2_addr, rd_addr  out  3 each  register indices from IR
- imm  out  16  sign-extended IR[5:0]
- reg_we  out  1  register write strobe, one cycle
- wb_from_mem  out  1  writeback source: 1=load data, 0=ALU result
- pc_we  out  1  PC update strobe, one cycle
- pc_branch  out  1  with pc_we: 1=PC+imm, 0=PC+1
- retire  out  1  one-cycle pulse per completed instruction
- illegal  out  1  high while in TRAP
- state_dbg  out  3  current state encoding

Behaviour:
- Encoding: op=IR[15:12], rd=IR[11:9], rs1=IR[8:6], rs2=IR[5:3], funct3=IR[2:0].
- Opcodes:
  - 0000 R-type: alu_ctrl=funct3; funct3 110/111 illegal.
  - 0001 ADDI: alu_ctrl=ADD.
  - 0010 LW: alu_ctrl=ADD.
  - 0011 SW: data register in the rd field, alu_ctrl=ADD.
  - 0100 BEQ: compares rd field with rs1 via SUB; rs2_addr driven = rd field.
  - All other opcodes illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset values:
  - state=FETCH, IR=16'h0.
  - All strobes and requests 0, alu_ctrl=000, illegal=0.
  - imem_req goes high the first cycle after reset deasserts.
  - Reset mid-operation aborts immediately: no pc_we, reg_we or dmem_req in the following cycle.
- FETCH: imem_req=1. On imem_valid, latch IR and go to DECODE; otherwise stay.
- DECODE: address and imm outputs become valid from IR. Illegal opcode/funct3 → TRAP; else → EXEC.
- EXEC: alu_ctrl and alu_src_imm are driven from IR in this state and held through MEM/WB.
  - R/ADDI → WB.
  - LW/SW → MEM.
  - BEQ: pc_we=1, pc_branch=alu_zero, retire=1, → FETCH.
- MEM: dmem_req=1, dmem_we=(op==SW). Wait for dmem_ready.
  - SW: pc_we=1, retire=1, → FETCH in the ready cycle.
  - LW → WB.
- WB: reg_we=1 (suppressed when rd==0), wb_from_mem=(op==LW), pc_we=1, pc_branch=0, retire=1, → FETCH.
- TRAP: all strobes 0, illegal=1; stays in TRAP until rst.
- Minimum latency with zero-wait memory:
  - BEQ and SW: 3 cycles (FETCH, DECODE, EXEC) + 1 MEM for SW = 4.
  - R/ADDI: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle on imem_valid or dmem_ready adds exactly one cycle.
- Outside the states listed above, reg_we, pc_we, dmem_req and retire are never asserted; retire is exactly one cycle per instruction.
- imm is sign-extended: IR[5] replicated into bits 15:6.
- imem_valid or dmem_ready arriving while its request is low is ignored.

Decomposition:
- Package mc16_pkg holds:
  - opcode localparams (OP_RTYPE..OP_BEQ).
  - alu_op_e enum (ADD..SLT, 3-bit) shared with the ALU.
  - ctrl_state_e enum with the encodings above.
- One sub-module, mc16_alu_dec: combinational (op, funct3) → (alu_ctrl, alu_src_imm, legal). Instantiated once in mc_ctrl16.

Test Plan:
- rst for 2 cycles, then release → imem_req=1 next cycle, all strobes 0, state_dbg=0, illegal=0.
- imem_rdata=16'h0281 (R-type, rd=1, rs1=2, rs2=0, funct3=001), zero-wait → alu_ctrl=001, alu_src_imm=0, reg_we+pc_we+retire in cycle 4, rd_addr=1.
- ADDI with imm=6'b111110 → imm=16'hFFFE, alu_src_imm=1, alu_ctrl=000.
- LW with dmem_ready delayed 3 cycles → dmem_req held 4 cycles, dmem_we=0, then WB with wb_from_mem=1; total 8 cycles.
- BEQ twice, alu_zero=1 then 0 → pc_we=1 in EXEC both times, pc_branch=1 then 0, no reg_we.
- R-type funct3=111 → TRAP: illegal=1, no retire, imem_req=0 for 10 cycles. Assert rst → back to FETCH.
